// File: rtl/rx_pkg.sv
// Shared definitions for the RX bit-FIFO sequencer: state encoding and
// the per-modulation OFDM block sizes (coded bits per symbol).
package rx_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_FILL  = 2'd1,
    RX_BURST = 2'd2,
    RX_FLUSH = 2'd3
  } rx_state_e;

  localparam int unsigned N_CBPS_BPSK  = 48;
  localparam int unsigned N_CBPS_QPSK  = 96;
  localparam int unsigned N_CBPS_16QAM = 192;
  localparam int unsigned N_CBPS_64QAM = 288;

endpackage

// File: rtl/rx_fifo_burst_ctrl.sv
// Sequencer between the demapper (FIFO writer) and the deinterleaver (FIFO
// reader). Gates writes, tracks occupancy, waits until one full block is
// buffered and then drains exactly that block as a ready-paced burst.
//
// Handshake: downstream takes a bit in every cycle where oOut_valid=1; the
// sequencer only raises oOut_valid when iDs_ready=1 in that same cycle, so
// oOut_valid is both "valid" and "transfer" (ready may drop at any time and
// simply pauses the burst without losing position).
module rx_fifo_burst_ctrl
  import rx_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int LEN_WIDTH  = 9
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic                  iEnable,
  input  logic [LEN_WIDTH-1:0]  iBlk_len,
  input  logic                  iIn_valid,
  input  logic                  iDs_ready,
  input  logic                  iFlush,
  input  logic                  iFifo_full,
  input  logic                  iFifo_empty,
  output logic                  oFifo_wen,
  output logic                  oFifo_ren,
  output logic                  oOut_valid,
  output logic                  oBurst_first,
  output logic                  oBurst_last,
  output logic                  oOverflow,
  output logic [ADDR_WIDTH:0]   oCount,
  output rx_state_e             oDbg_state
);

  localparam int CMP_W = (ADDR_WIDTH + 1 > LEN_WIDTH) ? ADDR_WIDTH + 1 : LEN_WIDTH;
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]  CNT_ONE = (ADDR_WIDTH + 1)'(1);

  rx_state_e              state_q, state_d;
  logic [ADDR_WIDTH:0]    count_q, count_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [LEN_WIDTH-1:0]   idx_q, idx_d;
  logic                   ovf_q, ovf_d;

  logic                   wen_s, ren_s;
  logic                   out_valid_s, first_s, last_s;
  logic                   len_load_s;
  logic [LEN_WIDTH-1:0]   load_len_s;
  logic [CMP_W-1:0]       count_ext, len_ext;
  logic                   count_ge_len;
  logic                   at_last_idx;

  // A zero block length would never complete a burst; treat it as one bit.
  assign load_len_s   = (iBlk_len == '0) ? LEN_ONE : iBlk_len;
  assign count_ext    = CMP_W'(count_q);
  assign len_ext      = CMP_W'(len_q);
  assign count_ge_len = (count_ext >= len_ext);
  assign at_last_idx  = (idx_q == (len_q - LEN_ONE));

  // Next-state, write gating, read strobes and burst markers.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    ovf_d       = ovf_q;
    wen_s       = iIn_valid & ~iFifo_full;
    ren_s       = 1'b0;
    out_valid_s = 1'b0;
    first_s     = 1'b0;
    last_s      = 1'b0;
    len_load_s  = 1'b0;

    if (state_q != RX_FLUSH && iIn_valid && iFifo_full) begin
      ovf_d = 1'b1;
    end

    case (state_q)
      RX_IDLE: begin
        if (iEnable) begin
          len_load_s = 1'b1;
          len_d      = load_len_s;
          state_d    = RX_FILL;
        end
      end
      RX_FILL: begin
        if (count_ge_len) begin
          idx_d   = '0;
          state_d = RX_BURST;
        end
      end
      RX_BURST: begin
        ren_s       = iDs_ready & ~iFifo_empty;
        out_valid_s = ren_s;
        first_s     = ren_s & (idx_q == '0);
        last_s      = ren_s & at_last_idx;
        if (ren_s) begin
          idx_d = idx_q + LEN_ONE;
          if (at_last_idx) begin
            if (iEnable) begin
              len_load_s = 1'b1;
              len_d      = load_len_s;
              state_d    = RX_FILL;
            end else begin
              state_d = RX_IDLE;
            end
          end
        end
      end
      RX_FLUSH: begin
        // Discard: read everything out, accept nothing new, show nothing downstream.
        wen_s = 1'b0;
        ren_s = ~iFifo_empty;
        if (count_q == '0 && !iFlush) begin
          ovf_d   = 1'b0;
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase

    if (iFlush) begin
      state_d = RX_FLUSH;
    end
  end

  // Occupancy follows the actual FIFO strobes; simultaneous read and write cancel.
  always_comb begin
    count_d = count_q;
    if (wen_s && !ren_s) begin
      count_d = count_q + CNT_ONE;
    end else if (ren_s && !wen_s) begin
      count_d = count_q - CNT_ONE;
    end
  end

  // State, occupancy, block length, bit index and sticky overflow registers.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= RX_IDLE;
      count_q <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
    end
  end

  // Write enable is the only strobe not qualified by state, so mask it in reset.
  assign oFifo_wen    = wen_s & iRst_n;
  assign oFifo_ren    = ren_s;
  assign oOut_valid   = out_valid_s;
  assign oBurst_first = first_s;
  assign oBurst_last  = last_s;
  assign oOverflow    = ovf_q;
  assign oCount       = count_q;
  assign oDbg_state   = state_q;

  // A block longer than the FIFO can never be fully buffered.
  a_len_fits: assert property (@(posedge iClk) disable iff (!iRst_n)
    len_load_s |-> (int'(iBlk_len) <= (1 << ADDR_WIDTH)));

  // The local count must agree with the FIFO's own empty flag.
  a_count_empty: assert property (@(posedge iClk) disable iff (!iRst_n)
    (count_q == '0) == iFifo_empty);

endmodule

// File: tb/tb_rx_fifo_burst_ctrl.sv
// Bench for the RX bit-FIFO sequencer: a behavioural FIFO occupancy model
// supplies the full/empty flags, and each scenario task predicts strobes,
// markers and occupancy from block-level arithmetic.
module tb_rx_fifo_burst_ctrl;
  import rx_pkg::*;

  localparam int DEPTH = 512;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [8:0] blk_len;
  logic       in_valid;
  logic       ds_ready;
  logic       flush;
  logic       fifo_full;
  logic       fifo_empty;
  logic       wen;
  logic       ren;
  logic       out_valid;
  logic       first;
  logic       last;
  logic       ovf;
  logic [9:0] count;
  rx_state_e  dbg_state;

  int tests_run;
  int tests_failed;
  int fifo_n;

  rx_fifo_burst_ctrl #(.ADDR_WIDTH(9), .LEN_WIDTH(9)) dut (
    .iClk         (clk),
    .iRst_n       (rst_n),
    .iEnable      (en),
    .iBlk_len     (blk_len),
    .iIn_valid    (in_valid),
    .iDs_ready    (ds_ready),
    .iFlush       (flush),
    .iFifo_full   (fifo_full),
    .iFifo_empty  (fifo_empty),
    .oFifo_wen    (wen),
    .oFifo_ren    (ren),
    .oOut_valid   (out_valid),
    .oBurst_first (first),
    .oBurst_last  (last),
    .oOverflow    (ovf),
    .oCount       (count),
    .oDbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural FIFO (occupancy only) ----------------
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) fifo_n <= 0;
    else        fifo_n <= fifo_n + (wen ? 1 : 0) - (ren ? 1 : 0);
  end
  assign fifo_full  = (fifo_n >= DEPTH);
  assign fifo_empty = (fifo_n <= 0);

  // ---------------- driver helpers ----------------
  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    en       = 1'b0;
    in_valid = 1'b0;
    ds_ready = 1'b0;
    flush    = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst_n    = 1'b0;
    en       = 1'b1;
    blk_len  = 9'd48;
    in_valid = 1'b1;
    ds_ready = 1'b1;
    flush    = 1'b0;
    #2;
    tests_run++; if (wen !== 1'b0) begin tests_failed++; $display("FAIL reset_wen: got %b want 0", wen); end
    tests_run++; if ({ren, out_valid, first, last} !== 4'b0) begin tests_failed++; $display("FAIL reset_read: got %b want 0000", {ren, out_valid, first, last}); end
    tests_run++; if (ovf !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    tests_run++; if (count !== 10'd0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", count); end
    next_cycle();
    idle_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++; if (dbg_state !== RX_IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d want %0d", dbg_state, RX_IDLE); end
    next_cycle();
  endtask

  // One block: enable, fill with gappy writes, check the one-cycle latency,
  // then drain with the given ready pattern (0 always, 1 toggle, 2 random).
  task automatic run_block(input int len_in, input int rdy_mode, input string tag);
    int         eff;
    int         wr_n;
    int         rd_n;
    int         cyc;
    int         drain_cyc;
    logic [1:0] exp_q[$];
    logic [1:0] exp_fl;
    eff = (len_in == 0) ? 1 : len_in;
    idle_inputs();
    blk_len = 9'(len_in);
    en      = 1'b1;
    @(negedge clk);
    tests_run++; if (dbg_state !== RX_IDLE) begin tests_failed++; $display("FAIL %s_start_state: got %0d want %0d", tag, dbg_state, RX_IDLE); end
    next_cycle();
    en      = 1'b0;
    blk_len = 9'($urandom_range(0, 511));
    wr_n = 0;
    cyc  = 0;
    while (wr_n < eff && cyc < 4000) begin
      in_valid = ($urandom_range(0, 3) != 0);
      ds_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      tests_run++; if (count !== 10'(wr_n)) begin tests_failed++; $display("FAIL %s_fill_count: got %0d want %0d", tag, count, wr_n); end
      tests_run++; if ({ren, out_valid} !== 2'b00) begin tests_failed++; $display("FAIL %s_fill_no_read: got %b want 00", tag, {ren, out_valid}); end
      tests_run++; if (wen !== in_valid) begin tests_failed++; $display("FAIL %s_fill_wen: got %b want %b", tag, wen, in_valid); end
      @(posedge clk);
      if (in_valid) wr_n++;
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    ds_ready = 1'b1;
    @(negedge clk);
    tests_run++; if (count !== 10'(eff)) begin tests_failed++; $display("FAIL %s_full_count: got %0d want %0d", tag, count, eff); end
    tests_run++; if (ren !== 1'b0) begin tests_failed++; $display("FAIL %s_latency: got ren=%b want 0", tag, ren); end
    next_cycle();
    for (int i = 0; i < eff; i++) exp_q.push_back({i == 0, i == eff - 1});
    rd_n      = 0;
    drain_cyc = 0;
    while (rd_n < eff && drain_cyc < 8 * eff + 16) begin
      case (rdy_mode)
        0:       ds_ready = 1'b1;
        1:       ds_ready = ((drain_cyc % 2) == 0);
        default: ds_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      tests_run++; if (ren !== ds_ready) begin tests_failed++; $display("FAIL %s_burst_ren: got %b want %b", tag, ren, ds_ready); end
      tests_run++; if (out_valid !== ds_ready) begin tests_failed++; $display("FAIL %s_burst_valid: got %b want %b", tag, out_valid, ds_ready); end
      tests_run++; if (count !== 10'(eff - rd_n)) begin tests_failed++; $display("FAIL %s_burst_count: got %0d want %0d", tag, count, eff - rd_n); end
      if (ren === 1'b1) begin
        exp_fl = exp_q.pop_front();
        tests_run++; if ({first, last} !== exp_fl) begin tests_failed++; $display("FAIL %s_markers bit %0d: got %b want %b", tag, rd_n, {first, last}, exp_fl); end
        rd_n++;
      end else begin
        tests_run++; if ({first, last} !== 2'b00) begin tests_failed++; $display("FAIL %s_markers_paused: got %b want 00", tag, {first, last}); end
      end
      next_cycle();
      drain_cyc++;
    end
    tests_run++; if (rd_n != eff) begin tests_failed++; $display("FAIL %s_burst_len: got %0d want %0d", tag, rd_n, eff); end
    if (rdy_mode == 1) begin
      tests_run++; if (drain_cyc != 2 * eff - 1) begin tests_failed++; $display("FAIL %s_pause_cycles: got %0d want %0d", tag, drain_cyc, 2 * eff - 1); end
    end
    ds_ready = 1'b0;
    @(negedge clk);
    tests_run++; if (dbg_state !== RX_IDLE) begin tests_failed++; $display("FAIL %s_end_state: got %0d want %0d", tag, dbg_state, RX_IDLE); end
    tests_run++; if (count !== 10'd0) begin tests_failed++; $display("FAIL %s_end_count: got %0d want 0", tag, count); end
    next_cycle();
  endtask

  task automatic test_single_block;
    run_block(48, 0, "blk48");
  endtask

  task automatic test_ready_toggle;
    run_block(96, 1, "toggle96");
  endtask

  task automatic test_len_zero;
    run_block(0, 0, "len0");
  endtask

  task automatic test_random_blocks;
    int lens[4];
    lens = '{N_CBPS_BPSK, N_CBPS_QPSK, N_CBPS_16QAM, N_CBPS_64QAM};
    for (int k = 0; k < 4; k++) begin
      run_block(lens[$urandom_range(0, 3)], 2, "rand");
    end
  endtask

  // Two blocks with writes continuing through the first burst.
  task automatic test_back_to_back;
    int  len;
    int  rd_before;
    int  wr_before;
    bit  exp_ren;
    bit  exp_first;
    bit  exp_last;
    len = ($urandom_range(0, 1) == 0) ? N_CBPS_BPSK : N_CBPS_QPSK;
    idle_inputs();
    blk_len = 9'(len);
    en      = 1'b1;
    next_cycle();
    rd_before = 0;
    for (int t = 0; t <= 3 * len + 1; t++) begin
      in_valid  = (t < 2 * len);
      ds_ready  = 1'b1;
      en        = (t < 2 * len + 2);
      wr_before = (t < 2 * len) ? t : 2 * len;
      exp_ren   = (t >= len + 1 && t <= 2 * len) || (t >= 2 * len + 2 && t <= 3 * len + 1);
      exp_first = exp_ren && (t == len + 1 || t == 2 * len + 2);
      exp_last  = exp_ren && (t == 2 * len || t == 3 * len + 1);
      @(negedge clk);
      tests_run++; if (ren !== exp_ren) begin tests_failed++; $display("FAIL b2b_ren t=%0d: got %b want %b", t, ren, exp_ren); end
      tests_run++; if (count !== 10'(wr_before - rd_before)) begin tests_failed++; $display("FAIL b2b_count t=%0d: got %0d want %0d", t, count, wr_before - rd_before); end
      tests_run++; if ({first, last} !== {exp_first, exp_last}) begin tests_failed++; $display("FAIL b2b_markers t=%0d: got %b want %b", t, {first, last}, {exp_first, exp_last}); end
      if (exp_ren) rd_before++;
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    tests_run++; if (dbg_state !== RX_IDLE) begin tests_failed++; $display("FAIL b2b_end_state: got %0d want %0d", dbg_state, RX_IDLE); end
    tests_run++; if (count !== 10'd0) begin tests_failed++; $display("FAIL b2b_end_count: got %0d want 0", count); end
    next_cycle();
  endtask

  // Pulse flush for one cycle, then expect n discard reads and a return to IDLE.
  task automatic do_flush(input int n, input logic ovf_before, input string tag);
    idle_inputs();
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    for (int k = 0; k <= n; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      tests_run++; if (ren !== (k < n)) begin tests_failed++; $display("FAIL %s_flush_ren k=%0d: got %b want %b", tag, k, ren, (k < n)); end
      tests_run++; if ({wen, out_valid, first, last} !== 4'b0) begin tests_failed++; $display("FAIL %s_flush_quiet k=%0d: got %b want 0000", tag, k, {wen, out_valid, first, last}); end
      if (k == n) begin
        tests_run++; if (ovf !== ovf_before) begin tests_failed++; $display("FAIL %s_flush_ovf_hold: got %b want %b", tag, ovf, ovf_before); end
      end
      next_cycle();
    end
    in_valid = 1'b0;
    @(negedge clk);
    tests_run++; if (dbg_state !== RX_IDLE) begin tests_failed++; $display("FAIL %s_flush_exit: got %0d want %0d", tag, dbg_state, RX_IDLE); end
    tests_run++; if (ovf !== 1'b0) begin tests_failed++; $display("FAIL %s_flush_ovf_clear: got %b want 0", tag, ovf); end
    tests_run++; if (count !== 10'd0) begin tests_failed++; $display("FAIL %s_flush_count: got %0d want 0", tag, count); end
    next_cycle();
  endtask

  task automatic test_overflow;
    idle_inputs();
    in_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) next_cycle();
    @(negedge clk);
    tests_run++; if (wen !== 1'b0) begin tests_failed++; $display("FAIL ovf_wen_blocked: got %b want 0", wen); end
    tests_run++; if (count !== 10'(DEPTH)) begin tests_failed++; $display("FAIL ovf_count_full: got %0d want %0d", count, DEPTH); end
    tests_run++; if (ovf !== 1'b0) begin tests_failed++; $display("FAIL ovf_early: got %b want 0", ovf); end
    next_cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++; if (ovf !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
      tests_run++; if (count !== 10'(DEPTH)) begin tests_failed++; $display("FAIL ovf_count_hold: got %0d want %0d", count, DEPTH); end
      next_cycle();
    end
    do_flush(DEPTH, 1'b1, "ovf");
  endtask

  task automatic test_flush_mid_fill;
    idle_inputs();
    blk_len = 9'd48;
    en      = 1'b1;
    next_cycle();
    en       = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 30; i++) next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    tests_run++; if (dbg_state !== RX_FILL) begin tests_failed++; $display("FAIL mid_fill_state: got %0d want %0d", dbg_state, RX_FILL); end
    tests_run++; if (count !== 10'd30) begin tests_failed++; $display("FAIL mid_fill_count: got %0d want 30", count); end
    next_cycle();
    do_flush(30, 1'b0, "fill30");
  endtask

  task automatic test_reset_mid_burst;
    int n_last;
    idle_inputs();
    blk_len = 9'd48;
    en      = 1'b1;
    next_cycle();
    en       = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 48; i++) next_cycle();
    in_valid = 1'b0;
    ds_ready = 1'b1;
    next_cycle();
    n_last = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (last === 1'b1) n_last++;
      next_cycle();
    end
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++; if ({wen, ren, out_valid, first, last, ovf} !== 6'b0) begin tests_failed++; $display("FAIL rst_burst_outputs: got %b want 000000", {wen, ren, out_valid, first, last, ovf}); end
    tests_run++; if (count !== 10'd0) begin tests_failed++; $display("FAIL rst_burst_count: got %0d want 0", count); end
    tests_run++; if (n_last != 0) begin tests_failed++; $display("FAIL rst_burst_no_last: got %0d want 0", n_last); end
    next_cycle();
    idle_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++; if (dbg_state !== RX_IDLE) begin tests_failed++; $display("FAIL rst_burst_state: got %0d want %0d", dbg_state, RX_IDLE); end
    tests_run++; if (count !== 10'd0) begin tests_failed++; $display("FAIL rst_burst_count_after: got %0d want 0", count); end
    next_cycle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_single_block();
    test_ready_toggle();
    test_len_zero();
    test_back_to_back();
    test_random_blocks();
    test_overflow();
    test_flush_mid_fill();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
